// File: rtl/dbg_host_master.sv
// Debug host master: turns debug commands into a UART byte protocol and checks the target's reply.
// Define DBG_HOST_TIMEOUT_EN to abort with an error when no response byte arrives within TIMEOUT_CYCLES.
module dbg_host_master #(
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_reg,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_RUN   = 3'd2;
    localparam logic [2:0] OP_HALT  = 3'd3;
    localparam logic [2:0] OP_RESET = 3'd4;

    state_t      state, next_state;
    logic [2:0]  op;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [4:0]  reg_idx;
    logic [2:0]  cnt;
    logic [23:0] shift;

    logic [7:0]  tx_byte, ack_byte;
    logic [2:0]  tx_last, rx_last;
    logic        rx_fire, bad_byte, timeout_hit, req_illegal, enter_done, done_err;

    // Per-command framing: byte to send at position cnt, last TX/RX index, and expected ack.
    always_comb begin
        tx_byte  = 8'h00;
        tx_last  = 3'd0;
        rx_last  = 3'd0;
        ack_byte = 8'h00;
        case (op)
            OP_WRITE: begin
                tx_last  = 3'd6;
                ack_byte = 8'hAA;
                case (cnt)
                    3'd0:    tx_byte = 8'hAA;
                    3'd1:    tx_byte = addr[15:8];
                    3'd2:    tx_byte = addr[7:0];
                    3'd3:    tx_byte = wdata[31:24];
                    3'd4:    tx_byte = wdata[23:16];
                    3'd5:    tx_byte = wdata[15:8];
                    default: tx_byte = wdata[7:0];
                endcase
            end
            OP_READ: begin
                tx_last = 3'd1;
                rx_last = 3'd3;
                tx_byte = (cnt == 3'd0) ? 8'hBB : {3'b000, reg_idx};
            end
            OP_RUN:   begin tx_byte = 8'hCC; ack_byte = 8'hCC; end
            OP_HALT:  begin tx_byte = 8'hDD; ack_byte = 8'hDD; end
            OP_RESET: begin tx_byte = 8'hEE; ack_byte = 8'hEE; end
            default:  ;
        endcase
    end

`ifdef DBG_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;

    // Idle-cycle counter, restarted by every received byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     timer <= '0;
        else if (state != WAIT_RSP || s_axis_tvalid) timer <= '0;
        else                                         timer <= timer + 1'b1;
    end

    assign timeout_hit = (state == WAIT_RSP) && !s_axis_tvalid && (timer == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign rx_fire     = (state == WAIT_RSP) && s_axis_tvalid;
    assign bad_byte    = rx_fire && (op != OP_READ) && (s_axis_tdata != ack_byte);
    assign req_illegal = (state == IDLE) && req_valid && (req_op > OP_RESET);
    assign done_err    = bad_byte || timeout_hit || req_illegal;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state    = state;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        s_axis_tready = 1'b0;
        case (state)
            IDLE: begin
                s_axis_tready = 1'b1;
                if (req_valid) next_state = (req_op > OP_RESET) ? DONE : SEND;
            end
            SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = tx_byte;
                if (m_axis_tready && cnt == tx_last) next_state = WAIT_RSP;
            end
            WAIT_RSP: begin
                s_axis_tready = 1'b1;
                if ((s_axis_tvalid && cnt == rx_last) || timeout_hit) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign enter_done = (next_state == DONE) && (state != DONE);
    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= 3'd0;
            addr      <= 16'h0000;
            wdata     <= 32'h0;
            reg_idx   <= 5'd0;
            cnt       <= 3'd0;
            shift     <= 24'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (req_valid) begin
                    op      <= req_op;
                    addr    <= req_addr;
                    wdata   <= req_wdata;
                    reg_idx <= req_reg;
                    cnt     <= 3'd0;
                end
                SEND: if (m_axis_tready) cnt <= (cnt == tx_last) ? 3'd0 : cnt + 3'd1;
                WAIT_RSP: if (s_axis_tvalid) begin
                    cnt   <= cnt + 3'd1;
                    shift <= {shift[15:0], s_axis_tdata};
                end
                default: ;
            endcase
            // Result registers change only when a command completes, so they hold between pulses.
            if (enter_done) begin
                rsp_err <= done_err;
                if (state == WAIT_RSP && op == OP_READ && !done_err)
                    rsp_rdata <= {shift, s_axis_tdata};
            end
        end
    end

endmodule

// File: tb/tb_dbg_host_master.sv
// Directed self-checking bench for dbg_host_master; the HALT timeout step runs only with DBG_HOST_TIMEOUT_EN.
module tb_dbg_host_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_reg = 5'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        busy;

    int checks = 0;
    int failures = 0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    dbg_host_master #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_reg(req_reg),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [2:0] op, input logic [15:0] a, input logic [31:0] d, input logic [4:0] r);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d; req_reg = r;
        check("req_ready_idle", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Collects n transferred bytes; with toggle, tready alternates 0/1 starting at 0 and held data is checked.
    task automatic run_tx(input int n, input bit toggle);
        int got = 0;
        int cyc = 0;
        bit holding = 1'b0;
        logic [7:0] held = 8'h00;
        tx_q.delete();
        while (got < n && cyc < 200) begin
            m_axis_tready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (holding) begin
                check("tx_hold_valid", m_axis_tvalid, 1'b1);
                check("tx_hold_data", m_axis_tdata, held);
            end
            holding = 1'b0;
            if (m_axis_tvalid) begin
                if (m_axis_tready) begin
                    tx_q.push_back(m_axis_tdata);
                    got++;
                end else begin
                    held = m_axis_tdata;
                    holding = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("tx_count", got, n);
    endtask

    task automatic compare_tx();
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("tx_byte%0d", i), (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]);
    endtask

    task automatic send_rx(input logic [7:0] b);
        s_axis_tvalid = 1'b1; s_axis_tdata = b;
        check("rx_ready", s_axis_tready, 1'b1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic err, input logic [31:0] rdata);
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_err"}, rsp_err, err);
        check({tag, "_rdata"}, rsp_rdata, rdata);
        @(negedge clk);
        check({tag, "_pulse_end"}, rsp_valid, 1'b0);
        check({tag, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        bit seen;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tdata", m_axis_tdata, 8'h00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", rsp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);

        // Byte arriving in IDLE is dropped
        send_rx(8'h99);
        check("idle_drop_busy", busy, 1'b0);
        check("idle_drop_rsp", rsp_valid, 1'b0);

        // WRITE_IMEM
        send_req(3'd0, 16'h0010, 32'h00500093, 5'd0);
        check("wr_busy", busy, 1'b1);
        check("wr_req_ready", req_ready, 1'b0);
        check("wr_s_ready_send", s_axis_tready, 1'b0);
        run_tx(7, 1'b0);
        exp_q = '{8'hAA, 8'h00, 8'h10, 8'h00, 8'h50, 8'h00, 8'h93};
        compare_tx();
        check("wr_wait_tvalid", m_axis_tvalid, 1'b0);
        send_rx(8'hAA);
        check_rsp("wr", 1'b0, 32'h0);

        // READ_REG
        send_req(3'd1, 16'h0, 32'h0, 5'd5);
        run_tx(2, 1'b0);
        exp_q = '{8'hBB, 8'h05};
        compare_tx();
        send_rx(8'h12);
        check("rd_no_early_rsp", rsp_valid, 1'b0);
        send_rx(8'h34);
        send_rx(8'h56);
        send_rx(8'h78);
        check_rsp("rd", 1'b0, 32'h12345678);

        // RUN with tready toggling and a bad ack
        send_req(3'd2, 16'h0, 32'h0, 5'd0);
        run_tx(1, 1'b1);
        exp_q = '{8'hCC};
        compare_tx();
        send_rx(8'h55);
        check_rsp("run", 1'b1, 32'h12345678);
        @(negedge clk);
        check("run_err_held", rsp_err, 1'b1);

        // HALT
        send_req(3'd3, 16'h0, 32'h0, 5'd0);
        run_tx(1, 1'b0);
        exp_q = '{8'hDD};
        compare_tx();
`ifdef DBG_HOST_TIMEOUT_EN
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("halt_timeout_cycles", n, 100);
        check_rsp("halt_to", 1'b1, 32'h12345678);
`else
        send_rx(8'hDD);
        check_rsp("halt", 1'b0, 32'h12345678);
`endif

        // RESET command
        send_req(3'd4, 16'h0, 32'h0, 5'd0);
        run_tx(1, 1'b0);
        exp_q = '{8'hEE};
        compare_tx();
        send_rx(8'hEE);
        check_rsp("reset_cmd", 1'b0, 32'h12345678);

        // Reset in the middle of a WRITE_IMEM after the third byte
        send_req(3'd0, 16'h1234, 32'hDEADBEEF, 5'd0);
        run_tx(3, 1'b0);
        m_axis_tready = 1'b0;
        check("mid_tvalid_before", m_axis_tvalid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_tvalid_rst", m_axis_tvalid, 1'b0);
        check("mid_busy_rst", busy, 1'b0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        rst = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        check("mid_req_ready", req_ready, 1'b1);
        repeat (5) begin
            if (rsp_valid || m_axis_tvalid) seen = 1'b1;
            @(negedge clk);
        end
        check("mid_no_rsp_or_tx", seen, 1'b0);

        // Illegal opcode
        send_req(3'd6, 16'h0, 32'h0, 5'd0);
        check("ill_tvalid", m_axis_tvalid, 1'b0);
        check_rsp("ill", 1'b1, 32'h0);
        check("ill_no_tx", m_axis_tvalid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbg_host_master.md
DBG_HOST_MASTER -- requirements
Module: dbg_host_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1200000, maximum idle cycles while awaiting a response byte (0.1 s at 12 MHz).
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high; one clock domain only.
REQ-004 SHALL have ports: req_valid input 1, req_ready output 1; request handshake.
REQ-005 SHALL have port: req_op  input  3  0=WRITE_IMEM, 1=READ_REG, 2=RUN, 3=HALT, 4=RESET, 5-7 illegal.
REQ-006 SHALL have ports: req_addr input 16 (write address), req_wdata input 32 (write word), req_reg input 5 (register index).
REQ-007 SHALL have ports: rsp_valid output 1 (one-cycle pulse), rsp_rdata output 32 (READ_REG result), rsp_err output 1 (failed command).
REQ-008 SHALL have ports: m_axis_tdata output 8, m_axis_tvalid output 1, m_axis_tready input 1; bytes to UART TX.
REQ-009 SHALL have ports: s_axis_tdata input 8, s_axis_tvalid input 1, s_axis_tready output 1; bytes from UART RX.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, SEND, WAIT_RSP, DONE; req_ready=1 only in IDLE.
REQ-012 SHALL latch req_op/addr/wdata/reg on req_valid&&req_ready and enter SEND; present first byte on m_axis the next cycle.
REQ-013 SHALL send byte sequences: WRITE_IMEM AA,addr[15:8],addr[7:0],wdata[31:24],[23:16],[15:8],[7:0]; READ_REG BB,{3'b0,reg}; RUN CC; HALT DD; RESET EE.
REQ-014 SHALL hold m_axis_tdata stable while m_axis_tvalid=1 and tready=0; advance only on tvalid&&tready; no bubble between bytes.
REQ-015 SHALL enter WAIT_RSP the cycle after the last byte transfers; expected response: WRITE_IMEM one byte AA, RUN CC, HALT DD, RESET EE, READ_REG four bytes MSB first.
REQ-016 SHALL drive s_axis_tready=1 in IDLE and WAIT_RSP, 0 in SEND and DONE; bytes received in IDLE are discarded.
REQ-017 SHALL set rsp_err=1 if any ack byte mismatches expected value, still completing via DONE.
REQ-018 SHALL assemble READ_REG bytes into rsp_rdata, updating rsp_rdata only on successful READ_REG completion; otherwise holds previous value.
REQ-019 SHALL pulse rsp_valid for exactly one cycle in DONE, the cycle after the final response byte, then return to IDLE.
REQ-020 SHALL for illegal req_op send no bytes and pulse rsp_valid with rsp_err=1 one cycle after acceptance.
REQ-021 SHALL hold rsp_err stable with rsp_rdata until the next rsp_valid.

Reset
REQ-022 SHALL on rst force state IDLE, req_ready=1 after release, m_axis_tvalid=0, m_axis_tdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, counters 0.
REQ-023 SHALL abort any in-flight command on rst without issuing rsp_valid.

Configuration
REQ-024 SHALL with DBG_HOST_TIMEOUT_EN defined count cycles in WAIT_RSP, clear on each received byte, and at TIMEOUT_CYCLES go to DONE with rsp_err=1.
REQ-025 SHALL without DBG_HOST_TIMEOUT_EN omit the counter and wait in WAIT_RSP indefinitely.

Verification
REQ-026 SHALL cover WRITE_IMEM addr=0x0010 wdata=0x00500093, tready=1, RX returns AA -> TX AA 00 10 00 50 00 93, rsp_valid pulse, rsp_err=0.
REQ-027 SHALL cover READ_REG reg=5, RX returns 12 34 56 78 -> TX BB 05, rsp_rdata=0x12345678, rsp_err=0.
REQ-028 SHALL cover RUN with tready toggling 1/0 every cycle and RX ack 0x55 -> TX CC held stable, rsp_err=1, rsp_rdata unchanged.
REQ-029 SHALL cover HALT with no RX byte, DBG_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=100 -> rsp_valid with rsp_err=1 exactly 100 cycles after WAIT_RSP entry.
REQ-030 SHALL cover rst asserted mid-WRITE_IMEM after third byte -> m_axis_tvalid=0, no rsp_valid, req_ready=1 after release; req_op=6 -> rsp_err=1 one cycle after acceptance, no TX bytes.
